rand_sched: RTL and testbench

RAND_SCHED -- requirements
Module: rand_sched

---
 rtl/rand_sched.sv | 111 +++++++++++
 tb/tb_rand_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rand_sched.sv
// rtl/rand_sched.sv - round-robin scheduler handing out words from a reseedable PRNG
// Optional automatic reseed every RESEED_INTERVAL grants: define RAND_SCHED_AUTO_RESEED_EN.
module rand_sched #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 64,
  parameter int WARMUP_CYCLES   = 8,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               gen_reset,
  input  logic [WIDTH-1:0]   rand_vect,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rand_out,
  input  logic               reseed_req,
  output logic               busy
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int WCW = $clog2(WARMUP_CYCLES);

  typedef enum logic [1:0] {ST_RESEED, ST_WARMUP, ST_SERVE} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, sel_idx;
  logic               sel_valid;
  logic [NUM_REQ-1:0] elig;
  logic [WCW-1:0]     wcnt;
  logic               grant_en, grant, interval_end;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    int j;
    elig      = req & ~gnt;
    sel_valid = 1'b0;
    sel_idx   = ptr;
    j         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!sel_valid && elig[PW'(j)]) begin
        sel_valid = 1'b1;
        sel_idx   = PW'(j);
      end
    end
  end

  assign grant = grant_en & sel_valid;

`ifdef RAND_SCHED_AUTO_RESEED_EN
  localparam int GCW = $clog2(RESEED_INTERVAL + 1);
  logic [GCW-1:0] gcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              gcnt <= '0;
    else if (state == ST_RESEED) gcnt <= '0;
    else if (grant)            gcnt <= gcnt + GCW'(1);
  end

  assign interval_end = grant && (gcnt == GCW'(RESEED_INTERVAL - 1));
`else
  logic unused_interval;
  assign unused_interval = (RESEED_INTERVAL == 0);
  assign interval_end    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RESEED;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESEED: state_nxt = ST_WARMUP;
      ST_WARMUP: if (wcnt == WCW'(WARMUP_CYCLES - 1)) state_nxt = ST_SERVE;
      ST_SERVE:  if (reseed_req || interval_end) state_nxt = ST_RESEED;
      default:   state_nxt = ST_RESEED;
    endcase
  end

  always_comb begin
    gen_reset = (state == ST_RESEED);
    busy      = (state != ST_SERVE);
    grant_en  = (state == ST_SERVE) && !reseed_req;
  end

  // Warm-up counter is held at zero outside WARMUP so it starts clean on entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                wcnt <= '0;
    else if (state == ST_WARMUP) wcnt <= wcnt + WCW'(1);
    else                         wcnt <= '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= '0;
      rand_out <= '0;
      ptr      <= PW'(NUM_REQ - 1);
    end else begin
      gnt <= '0;
      if (grant) begin
        gnt      <= NUM_REQ'(1) << sel_idx;
        rand_out <= rand_vect;
        ptr      <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_rand_sched.sv
// tb/tb_rand_sched.sv - randomized check of rand_sched against a behavioural model
module tb_rand_sched;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int WU = 8;
  localparam int RI = 4;
`ifdef RAND_SCHED_AUTO_RESEED_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         gen_reset;
  logic [W-1:0] rand_vect;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] rand_out;
  logic         reseed_req;
  logic         busy;

  rand_sched #(.NUM_REQ(N), .WIDTH(W), .WARMUP_CYCLES(WU), .RESEED_INTERVAL(RI)) dut (
    .clk(clk), .reset_n(reset_n), .gen_reset(gen_reset), .rand_vect(rand_vect),
    .req(req), .gnt(gnt), .rand_out(rand_out), .reseed_req(reseed_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: busy_left = cycles until serving resumes (WU+1 means the reseed cycle)
  int           busy_left, last, grants, ngrants, cyc, first_gnt, gr_count, auto_cnt;
  logic [N-1:0] exp_gnt, req_pat;
  logic [W-1:0] exp_rand;
  bit           rand_req;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_left = WU + 1;
    last      = N - 1;
    grants    = 0;
    exp_gnt   = '0;
    exp_rand  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, W'(gnt), '0);
    chk({tag, "_rand_out"}, rand_out, '0);
    chk({tag, "_gen_reset"}, W'(gen_reset), 1);
    chk({tag, "_busy"}, W'(busy), 1);
  endtask

  task automatic tick(input bit pulse);
    logic [N-1:0] elig, n_gnt;
    logic [W-1:0] n_rand;
    bit           found;
    int           idx;
    @(negedge clk);
    chk("gnt", W'(gnt), W'(exp_gnt));
    chk("rand_out", rand_out, exp_rand);
    chk("busy", W'(busy), W'(busy_left > 0));
    chk("gen_reset", W'(gen_reset), W'(busy_left == WU + 1));
    if (gnt != 0 && first_gnt < 0) first_gnt = cyc;
    if (gen_reset) gr_count++;
    req        = rand_req ? N'($urandom) : req_pat;
    reseed_req = pulse;
    rand_vect  = {$urandom, $urandom};
    n_gnt  = '0;
    n_rand = exp_rand;
    found  = 1'b0;
    if (busy_left > 0) begin
      busy_left--;
    end else if (pulse) begin
      busy_left = WU + 1;
    end else begin
      elig = req & ~exp_gnt;
      for (int k = 1; k <= N; k++) begin
        idx = (last + k) % N;
        if (!found && elig[idx]) begin
          found      = 1'b1;
          n_gnt[idx] = 1'b1;
          n_rand     = rand_vect;
          last       = idx;
        end
      end
      if (found) begin
        grants++;
        ngrants++;
        if (AUTO && grants == RI) begin
          busy_left = WU + 1;
          grants    = 0;
          auto_cnt++;
        end
      end
    end
    @(posedge clk);
    exp_gnt  = n_gnt;
    exp_rand = n_rand;
    cyc++;
  endtask

  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int target;
    reset_n    = 1'b0;
    req        = '0;
    reseed_req = 1'b0;
    rand_vect  = '0;
    rand_req   = 1'b0;
    req_pat    = '0;
    ngrants    = 0;
    gr_count   = 0;
    auto_cnt   = 0;
    model_reset();
    #3 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc       = 0;
    first_gnt = -1;

    req_pat = 4'b0001;
    repeat (20) tick(1'b0);
    chk("first_gnt_cycle", W'(first_gnt), W'(WU + 2));

    req_pat = 4'b1111;
    repeat (12) tick(1'b0);

    req_pat = 4'b0011;
    tick(1'b1);
    repeat (15) tick(1'b0);

    tick(1'b1);
    repeat (3) tick(1'b0);
    tick(1'b1);
    repeat (12) tick(1'b0);

    req_pat  = 4'b0101;
    gr_count = 0;
    auto_cnt = 0;
    target   = ngrants + 100;
    for (int i = 0; i < 400 && ngrants < target; i++) tick(1'b0);
    chk("grant_window_reached", W'(ngrants >= target), 1);
    req_pat = 4'b0000;
    repeat (12) tick(1'b0);
    chk("gen_reset_pulses", W'(gr_count), W'(auto_cnt));

    rand_req = 1'b1;
    repeat (300) tick($urandom_range(0, 39) == 0);

    rand_req = 1'b0;
    req_pat  = 4'b1111;
    tick(1'b1);
    repeat (3) tick(1'b0);
    async_reset("rst_warmup");
    repeat (14) tick(1'b0);
    for (int i = 0; i < 40 && exp_gnt == 0; i++) tick(1'b0);
    async_reset("rst_grant");
    req_pat = 4'b0011;
    repeat (20) tick(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
